elevator_scan_ctrl: RTL

ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

---
 rtl/elevator_scan_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN controller: the car keeps sweeping one way while calls remain
// ahead of it, then reverses; door dwell, reopen and emergency stop included.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS        = 8,
    parameter int TRAVEL_CYCLES     = 4,
    parameter int DOOR_OPEN_CYCLES  = 10,
    parameter int DOOR_CLOSE_CYCLES = 3,
    localparam int FLOOR_W = ($clog2(NUM_FLOORS) < 1) ? 1 : $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  door_hold,
    input  logic                  estop,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  moving,
    output logic                  door,
    output logic                  direction,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  arrive,
    output logic                  halted
);

    localparam int CNT_MAX_A = (TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ? TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > DOOR_CLOSE_CYCLES) ? CNT_MAX_A : DOOR_CLOSE_CYCLES;
    localparam int CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] OPEN_LOAD   = CNT_W'(DOOR_OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLOSE_LOAD  = CNT_W'(DOOR_CLOSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        TRAVEL,
        DOOR_OPEN,
        DOOR_CLOSING,
        HALT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
        return m;
    endfunction

    logic [FLOOR_W-1:0]    next_floor;
    logic [NUM_FLOORS-1:0] here_bit, next_bit, req_latch, clr_mask, pending_next;
    logic                  pend_here, pend_up, pend_down, pend_ahead, pend_behind;
    logic                  nf_pend, nf_ahead, req_here, at_door, arriving;

    // next_floor is only meaningful while travelling, where it always stays in range
    assign next_floor  = direction ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
    assign here_bit    = NUM_FLOORS'(1) << floor;
    assign next_bit    = NUM_FLOORS'(1) << next_floor;
    assign pend_here   = |(pending & here_bit);
    assign pend_up     = |(pending & above_mask(floor));
    assign pend_down   = |(pending & below_mask(floor));
    assign pend_ahead  = direction ? pend_up : pend_down;
    assign pend_behind = direction ? pend_down : pend_up;
    assign nf_pend     = |(pending & next_bit);
    assign nf_ahead    = |(pending & (direction ? above_mask(next_floor) : below_mask(next_floor)));
    assign req_here    = |(req & here_bit);
    assign at_door     = (state == DOOR_OPEN) || (state == DOOR_CLOSING);
    assign arriving    = (state == TRAVEL) && (cnt == '0);

    // A call for the floor whose door is open or closing is served by the door itself
    assign req_latch = at_door ? (req & ~here_bit) : req;

    always_comb begin
        clr_mask = '0;
        if (!estop) begin
            if (((state == IDLE) || (state == DECIDE)) && pend_here)
                clr_mask = here_bit;
            else if (arriving && nf_pend)
                clr_mask = next_bit;
        end
    end

    assign pending_next = (pending | req_latch) & ~clr_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            floor     <= '0;
            moving    <= 1'b0;
            door      <= 1'b0;
            direction <= 1'b1;
            pending   <= '0;
            arrive    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            pending <= pending_next;
            arrive  <= 1'b0;
            if (estop) begin
                state  <= HALT;
                cnt    <= '0;
                moving <= 1'b0;
                door   <= 1'b0;
                halted <= 1'b1;
            end else begin
                moving <= 1'b0;
                door   <= 1'b0;
                halted <= 1'b0;
                case (state)
                    IDLE: begin
                        if (pend_here) begin
                            state <= DOOR_OPEN;
                            cnt   <= OPEN_LOAD;
                            door  <= 1'b1;
                        end else if (|pending) begin
                            state <= DECIDE;
                        end
                    end
                    DECIDE: begin
                        if (pend_here) begin
                            state <= DOOR_OPEN;
                            cnt   <= OPEN_LOAD;
                            door  <= 1'b1;
                        end else if (pend_ahead) begin
                            state  <= TRAVEL;
                            cnt    <= TRAVEL_LOAD;
                            moving <= 1'b1;
                        end else if (pend_behind) begin
                            state     <= TRAVEL;
                            cnt       <= TRAVEL_LOAD;
                            moving    <= 1'b1;
                            direction <= ~direction;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    TRAVEL: begin
                        if (cnt == '0) begin
                            floor  <= next_floor;
                            arrive <= 1'b1;
                            if (nf_pend) begin
                                state <= DOOR_OPEN;
                                cnt   <= OPEN_LOAD;
                                door  <= 1'b1;
                            end else if (nf_ahead) begin
                                cnt    <= TRAVEL_LOAD;
                                moving <= 1'b1;
                            end else begin
                                state <= DECIDE;
                            end
                        end else begin
                            cnt    <= cnt - CNT_W'(1);
                            moving <= 1'b1;
                        end
                    end
                    DOOR_OPEN: begin
                        if (door_hold || req_here) begin
                            cnt  <= OPEN_LOAD;
                            door <= 1'b1;
                        end else if (cnt == '0) begin
                            state <= DOOR_CLOSING;
                            cnt   <= CLOSE_LOAD;
                        end else begin
                            cnt  <= cnt - CNT_W'(1);
                            door <= 1'b1;
                        end
                    end
                    DOOR_CLOSING: begin
                        if (door_hold || req_here) begin
                            state <= DOOR_OPEN;
                            cnt   <= OPEN_LOAD;
                            door  <= 1'b1;
                        end else if (cnt == '0) begin
                            state <= DECIDE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    HALT: begin
                        state <= DECIDE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
